// File: rtl/ansi_escape_encoder_pkg.sv
// Shared codes and FSM state type for the ANSI escape encoder.
// Build option ANSI_ENC_CRLF_EN adds the LF state used to expand CR into CR LF.
package ansi_escape_encoder_pkg;

  localparam logic [7:0] CMD_UP         = 8'h11;
  localparam logic [7:0] CMD_DOWN       = 8'h12;
  localparam logic [7:0] CMD_RIGHT      = 8'h13;
  localparam logic [7:0] CMD_LEFT       = 8'h14;
  localparam logic [7:0] CMD_END        = 8'h15;
  localparam logic [7:0] CMD_HOME       = 8'h16;
  localparam logic [7:0] CMD_CLS        = 8'h17;
  localparam logic [7:0] CMD_ERASE_EOL  = 8'h18;
  localparam logic [7:0] CMD_ERASE_SOL  = 8'h19;
  localparam logic [7:0] CMD_ERASE_LINE = 8'h1A;
  localparam logic [7:0] CMD_INSTOG     = 8'h1C;
  localparam logic [7:0] CMD_DEL        = 8'h1D;
  localparam logic [7:0] CMD_PGUP       = 8'h1E;
  localparam logic [7:0] CMD_PGDN       = 8'h1F;

  localparam logic [7:0] CHAR_ESC         = 8'h1B;
  localparam logic [7:0] CHAR_LEFTBRACKET = 8'h5B;
  localparam logic [7:0] CHAR_TILDE       = 8'h7E;
  localparam logic [7:0] CHAR_CR          = 8'h0D;
  localparam logic [7:0] CHAR_LF          = 8'h0A;

  localparam logic [7:0] CHAR_A = 8'h41;
  localparam logic [7:0] CHAR_B = 8'h42;
  localparam logic [7:0] CHAR_C = 8'h43;
  localparam logic [7:0] CHAR_D = 8'h44;
  localparam logic [7:0] CHAR_F = 8'h46;
  localparam logic [7:0] CHAR_H = 8'h48;
  localparam logic [7:0] CHAR_J = 8'h4A;
  localparam logic [7:0] CHAR_K = 8'h4B;

  localparam logic [7:0] DIGIT_1 = 8'h31;
  localparam logic [7:0] DIGIT_2 = 8'h32;
  localparam logic [7:0] DIGIT_3 = 8'h33;
  localparam logic [7:0] DIGIT_5 = 8'h35;
  localparam logic [7:0] DIGIT_6 = 8'h36;

  typedef enum logic [2:0] {
    IDLE,
    ESC,
    BRKT,
    PARAM,
    FINAL,
    GAP
`ifdef ANSI_ENC_CRLF_EN
    , LF
`endif
  } state_t;

endpackage

// File: rtl/ansi_enc_lut.sv
// Combinational decode of a command code into its escape-sequence fields.
// Ports: i_code in; o_isCmd, o_hasParam, o_paramChar, o_finalChar out.
module ansi_enc_lut
  import ansi_escape_encoder_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_isCmd,
  output logic       o_hasParam,
  output logic [7:0] o_paramChar,
  output logic [7:0] o_finalChar
);

  always_comb begin
    o_isCmd     = 1'b1;
    o_hasParam  = 1'b0;
    o_paramChar = DIGIT_2;
    // plain chars reuse the final field as their single byte
    o_finalChar = i_code;
    unique case (i_code)
      CMD_UP:    o_finalChar = CHAR_A;
      CMD_DOWN:  o_finalChar = CHAR_B;
      CMD_RIGHT: o_finalChar = CHAR_C;
      CMD_LEFT:  o_finalChar = CHAR_D;
      CMD_END:   o_finalChar = CHAR_F;
      CMD_HOME:  o_finalChar = CHAR_H;
      CMD_CLS: begin
        o_hasParam  = 1'b1;
        o_finalChar = CHAR_J;
      end
      CMD_ERASE_EOL: o_finalChar = CHAR_K;
      CMD_ERASE_SOL: begin
        o_hasParam  = 1'b1;
        o_paramChar = DIGIT_1;
        o_finalChar = CHAR_K;
      end
      CMD_ERASE_LINE: begin
        o_hasParam  = 1'b1;
        o_finalChar = CHAR_K;
      end
      CMD_INSTOG: begin
        o_hasParam  = 1'b1;
        o_finalChar = CHAR_TILDE;
      end
      CMD_DEL: begin
        o_hasParam  = 1'b1;
        o_paramChar = DIGIT_3;
        o_finalChar = CHAR_TILDE;
      end
      CMD_PGUP: begin
        o_hasParam  = 1'b1;
        o_paramChar = DIGIT_5;
        o_finalChar = CHAR_TILDE;
      end
      CMD_PGDN: begin
        o_hasParam  = 1'b1;
        o_paramChar = DIGIT_6;
        o_finalChar = CHAR_TILDE;
      end
      default: o_isCmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/ansi_escape_encoder.sv
// Turns keyboard command codes into ANSI escape byte streams for a UART TX.
// Ports: clk, resetn (sync, low); cmdInValid/cmdIn/cmdInReady in;
// txDataOutValid/txDataOut/txReady out; seqBusy. Option: ANSI_ENC_CRLF_EN.
module ansi_escape_encoder
  import ansi_escape_encoder_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmdInValid,
  input  logic [7:0] cmdIn,
  output logic       cmdInReady,
  output logic       txDataOutValid,
  output logic [7:0] txDataOut,
  input  logic       txReady,
  output logic       seqBusy
);

  localparam logic [3:0] GAP_LOAD =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t     r_state, w_state;
  state_t     r_resume, w_resume;
  state_t     w_after;
  logic [3:0] r_gapCnt, w_gapCnt;
  logic [7:0] r_param, w_param;
  logic [7:0] r_final, w_final;
  logic       r_hasParam, w_hasParam;
  logic [7:0] r_txData, w_txData;
  logic       r_txValid, w_txValid;
`ifdef ANSI_ENC_CRLF_EN
  logic       r_crlf, w_crlf;
`endif

  logic       w_isCmd;
  logic       w_lutHasParam;
  logic [7:0] w_lutParam;
  logic [7:0] w_lutFinal;

  ansi_enc_lut u_lut (
    .i_code      (cmdIn),
    .o_isCmd     (w_isCmd),
    .o_hasParam  (w_lutHasParam),
    .o_paramChar (w_lutParam),
    .o_finalChar (w_lutFinal)
  );

  function automatic logic [7:0] byteOf(
    input state_t     s,
    input logic [7:0] p,
    input logic [7:0] f
  );
    logic [7:0] b;
    unique case (s)
      ESC:   b = CHAR_ESC;
      BRKT:  b = CHAR_LEFTBRACKET;
      PARAM: b = p;
`ifdef ANSI_ENC_CRLF_EN
      LF:    b = CHAR_LF;
`endif
      default: b = f;
    endcase
    return b;
  endfunction

  // byte state that follows the one currently presented
  always_comb begin
    w_after = IDLE;
    unique case (r_state)
      ESC:   w_after = BRKT;
      BRKT:  w_after = r_hasParam ? PARAM : FINAL;
      PARAM: w_after = FINAL;
`ifdef ANSI_ENC_CRLF_EN
      FINAL: w_after = r_crlf ? LF : IDLE;
`endif
      default: w_after = IDLE;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_resume   = r_resume;
    w_gapCnt   = r_gapCnt;
    w_param    = r_param;
    w_final    = r_final;
    w_hasParam = r_hasParam;
    w_txData   = r_txData;
    w_txValid  = r_txValid;
`ifdef ANSI_ENC_CRLF_EN
    w_crlf     = r_crlf;
`endif
    unique case (r_state)
      IDLE: begin
        if (cmdInValid) begin
          w_param    = w_lutParam;
          w_final    = w_lutFinal;
          w_hasParam = w_lutHasParam;
          w_txValid  = 1'b1;
`ifdef ANSI_ENC_CRLF_EN
          w_crlf     = ~w_isCmd & (cmdIn == CHAR_CR);
`endif
          if (w_isCmd) begin
            w_state  = ESC;
            w_txData = CHAR_ESC;
          end else begin
            w_state  = FINAL;
            w_txData = cmdIn;
          end
        end
      end
      GAP: begin
        if (r_gapCnt == 4'd0) begin
          w_state   = r_resume;
          w_txValid = 1'b1;
          w_txData  = byteOf(r_resume, r_param, r_final);
        end else begin
          w_gapCnt = r_gapCnt - 4'd1;
        end
      end
      default: begin
        // a byte is on the wire; move only on handshake
        if (txReady) begin
          if (w_after == IDLE) begin
            w_state   = IDLE;
            w_txValid = 1'b0;
          end else if (GAP_CYCLES == 0) begin
            w_state  = w_after;
            w_txData = byteOf(w_after, r_param, r_final);
          end else begin
            w_state   = GAP;
            w_resume  = w_after;
            w_gapCnt  = GAP_LOAD;
            w_txValid = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_resume   <= IDLE;
      r_gapCnt   <= 4'd0;
      r_param    <= 8'h00;
      r_final    <= 8'h00;
      r_hasParam <= 1'b0;
      r_txData   <= 8'h00;
      r_txValid  <= 1'b0;
`ifdef ANSI_ENC_CRLF_EN
      r_crlf     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_resume   <= w_resume;
      r_gapCnt   <= w_gapCnt;
      r_param    <= w_param;
      r_final    <= w_final;
      r_hasParam <= w_hasParam;
      r_txData   <= w_txData;
      r_txValid  <= w_txValid;
`ifdef ANSI_ENC_CRLF_EN
      r_crlf     <= w_crlf;
`endif
    end
  end

  assign cmdInReady     = (r_state == IDLE);
  assign seqBusy        = (r_state != IDLE);
  assign txDataOut      = r_txData;
  assign txDataOutValid = r_txValid;

endmodule

// File: tb/tb_ansi_escape_encoder.sv
// Directed bench for ansi_escape_encoder: vector table plus
// hand sequences for stall, gap spacing, throughput and reset abort.
module tb_ansi_escape_encoder;
  import ansi_escape_encoder_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmdInValid = 1'b0;
  logic [7:0] cmdIn = 8'h00;
  logic       cmdInReady;
  logic       txDataOutValid;
  logic [7:0] txDataOut;
  logic       txReady = 1'b1;
  logic       seqBusy;

  logic       gValid = 1'b0;
  logic [7:0] gCmd = 8'h00;
  logic       gReady;
  logic       gTxValid;
  logic [7:0] gTx;
  logic       gBusy;

  always #5 clk = ~clk;

  ansi_escape_encoder #(.GAP_CYCLES(0)) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmdInValid     (cmdInValid),
    .cmdIn          (cmdIn),
    .cmdInReady     (cmdInReady),
    .txDataOutValid (txDataOutValid),
    .txDataOut      (txDataOut),
    .txReady        (txReady),
    .seqBusy        (seqBusy)
  );

  ansi_escape_encoder #(.GAP_CYCLES(3)) u_gap (
    .clk            (clk),
    .resetn         (resetn),
    .cmdInValid     (gValid),
    .cmdIn          (gCmd),
    .cmdInReady     (gReady),
    .txDataOutValid (gTxValid),
    .txDataOut      (gTx),
    .txReady        (1'b1),
    .seqBusy        (gBusy)
  );

  typedef struct packed {
    logic [7:0]      cmd;
    logic [2:0]      n;
    logic [3:0][7:0] b;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] log_b[$];
  int         log_c[$];
  logic       log_r[$];
  logic [7:0] glog_b[$];
  int         glog_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txDataOutValid && txReady) begin
      log_b.push_back(txDataOut);
      log_c.push_back(cyc);
      log_r.push_back(cmdInReady);
    end
    if (gTxValid) begin
      glog_b.push_back(gTx);
      glog_c.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic [2:0] n,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.cmd = c;
    v.n = n;
    v.b[0] = b0;
    v.b[1] = b1;
    v.b[2] = b2;
    v.b[3] = b3;
    return v;
  endfunction

  task automatic clr();
    log_b.delete();
    log_c.delete();
    log_r.delete();
  endtask

  // call at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send(input logic [7:0] c, output int acc);
    int k = 0;
    while (!cmdInReady && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cmdInReady) chk("send_ready_timeout", 0, 1);
    cmdIn = c;
    cmdInValid = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    cmdInValid = 1'b0;
    cmdIn = 8'hFF;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (seqBusy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (seqBusy) chk("idle_timeout", 0, 1);
  endtask

  vec_t vec[$];

  initial begin
    int acc, a2;
    int k;

    vec.push_back(mk(CMD_UP,    3, 8'h1B, 8'h5B, 8'h41, 8'h00));
    vec.push_back(mk(CMD_DOWN,  3, 8'h1B, 8'h5B, 8'h42, 8'h00));
    vec.push_back(mk(CMD_RIGHT, 3, 8'h1B, 8'h5B, 8'h43, 8'h00));
    vec.push_back(mk(CMD_LEFT,  3, 8'h1B, 8'h5B, 8'h44, 8'h00));
    vec.push_back(mk(CMD_END,   3, 8'h1B, 8'h5B, 8'h46, 8'h00));
    vec.push_back(mk(CMD_HOME,  3, 8'h1B, 8'h5B, 8'h48, 8'h00));
    vec.push_back(mk(CMD_CLS,   4, 8'h1B, 8'h5B, 8'h32, 8'h4A));
    vec.push_back(mk(CMD_ERASE_EOL,  3, 8'h1B, 8'h5B, 8'h4B, 8'h00));
    vec.push_back(mk(CMD_ERASE_SOL,  4, 8'h1B, 8'h5B, 8'h31, 8'h4B));
    vec.push_back(mk(CMD_ERASE_LINE, 4, 8'h1B, 8'h5B, 8'h32, 8'h4B));
    vec.push_back(mk(CMD_INSTOG, 4, 8'h1B, 8'h5B, 8'h32, 8'h7E));
    vec.push_back(mk(CMD_DEL,    4, 8'h1B, 8'h5B, 8'h33, 8'h7E));
    vec.push_back(mk(CMD_PGUP,   4, 8'h1B, 8'h5B, 8'h35, 8'h7E));
    vec.push_back(mk(8'hC1,      1, 8'hC1, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(CMD_PGDN,   4, 8'h1B, 8'h5B, 8'h36, 8'h7E));
    vec.push_back(mk(8'h41,      1, 8'h41, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(8'h1B,      1, 8'h1B, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(8'h00,      1, 8'h00, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(8'h10,      1, 8'h10, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(8'h0A,      1, 8'h0A, 8'h00, 8'h00, 8'h00));
    vec.push_back(mk(8'hFF,      1, 8'hFF, 8'h00, 8'h00, 8'h00));
`ifdef ANSI_ENC_CRLF_EN
    vec.push_back(mk(8'h0D,      2, 8'h0D, 8'h0A, 8'h00, 8'h00));
`else
    vec.push_back(mk(8'h0D,      1, 8'h0D, 8'h00, 8'h00, 8'h00));
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(txDataOutValid), 0);
    chk("rst_data", int'(txDataOut), 0);
    chk("rst_busy", int'(seqBusy), 0);
    chk("rst_ready", int'(cmdInReady), 1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // table: every byte back-to-back from acceptance+1, ready low throughout
    foreach (vec[i]) begin
      clr();
      send(vec[i].cmd, acc);
      wait_idle();
      chk($sformatf("cnt_%02h", vec[i].cmd), log_b.size(), int'(vec[i].n));
      for (int j = 0; j < int'(vec[i].n) && j < log_b.size(); j++) begin
        chk($sformatf("byte_%02h_%0d", vec[i].cmd, j),
            int'(log_b[j]), int'(vec[i].b[j]));
        chk($sformatf("time_%02h_%0d", vec[i].cmd, j),
            log_c[j] - acc, 1 + j);
        chk($sformatf("rdy_%02h_%0d", vec[i].cmd, j), int'(log_r[j]), 0);
      end
    end

    // pass-through throughput: one item every 2 cycles
    clr();
    send(8'h61, acc);
    send(8'h62, a2);
    wait_idle();
    chk("thru_spacing", a2 - acc, 2);
    chk("thru_cnt", log_b.size(), 2);
    if (log_b.size() == 2) begin
      chk("thru_b0", int'(log_b[0]), 8'h61);
      chk("thru_b1", int'(log_b[1]), 8'h62);
    end

    // CLS with txReady stalled 5 cycles on '['
    clr();
    send(CMD_CLS, acc);
    @(posedge clk); #1;
    txReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid_%0d", i), int'(txDataOutValid), 1);
      chk($sformatf("stall_data_%0d", i), int'(txDataOut), 8'h5B);
      @(posedge clk); #1;
    end
    txReady = 1'b1;
    wait_idle();
    chk("stall_cnt", log_b.size(), 4);
    if (log_b.size() == 4) begin
      chk("stall_b0", int'(log_b[0]), 8'h1B);
      chk("stall_b1", int'(log_b[1]), 8'h5B);
      chk("stall_b2", int'(log_b[2]), 8'h32);
      chk("stall_b3", int'(log_b[3]), 8'h4A);
    end

    // GAP_CYCLES=3 instance: bytes 4 cycles apart
    glog_b.delete();
    glog_c.delete();
    chk("gap_ready", int'(gReady), 1);
    gCmd = CMD_ERASE_SOL;
    gValid = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    gValid = 1'b0;
    gCmd = 8'h00;
    k = 0;
    while (gBusy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (gBusy) chk("gap_timeout", 0, 1);
    chk("gap_cnt", glog_b.size(), 4);
    if (glog_b.size() == 4) begin
      chk("gap_b0", int'(glog_b[0]), 8'h1B);
      chk("gap_b1", int'(glog_b[1]), 8'h5B);
      chk("gap_b2", int'(glog_b[2]), 8'h31);
      chk("gap_b3", int'(glog_b[3]), 8'h4B);
      for (int j = 0; j < 4; j++)
        chk($sformatf("gap_time_%0d", j), glog_c[j] - acc, 1 + 4 * j);
    end

    // reset while '[' of CMD_DEL is on the wire
    clr();
    send(CMD_DEL, acc);
    @(posedge clk); #1;
    chk("abort_pre_data", int'(txDataOut), 8'h5B);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", int'(txDataOutValid), 0);
    chk("abort_ready", int'(cmdInReady), 1);
    chk("abort_busy", int'(seqBusy), 0);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_cnt", log_b.size(), 2);
    if (log_b.size() == 2) begin
      chk("abort_b0", int'(log_b[0]), 8'h1B);
      chk("abort_b1", int'(log_b[1]), 8'h5B);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
